// File: rtl/mash_ddsm_param.sv
// mash_ddsm_param
// Parametrised MASH 1-1-1-1 delta-sigma modulator driving the multi-modulus
// divider control word. Up to ORDER_MAX cascaded 1-bit accumulator stages,
// with the order selected at runtime. It includes an LFSR dither source,
// load-captured int/frac/order registers, and a saturating integer+noise
// output stage.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_en         advance strobe; all modulator state holds while low
//   i_load       capture i_int / i_frac / i_order into the active registers
//   i_int        integer divide value
//   i_frac       unsigned fraction, value = i_frac / 2^ACC_W
//   i_order      requested order minus one (clamped to ORDER_MAX-1)
//   i_dither_en  add the LFSR bit to the stage-1 input LSB
//   i_seed       LFSR reset value (0 maps to 1)
//   o_mash_out   clamped int_act + noise-cancelled carry word
//   o_valid      o_mash_out updated this cycle
//   o_sat        current o_mash_out was clamped
module mash_ddsm_param #(
    parameter int ACC_W     = 24,
    parameter int ORDER_MAX = 4,
    parameter int INT_W     = 8,
    parameter int LFSR_W    = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [INT_W-1:0]  i_int,
    input  logic [ACC_W-1:0]  i_frac,
    input  logic [1:0]        i_order,
    input  logic              i_dither_en,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [INT_W-1:0]  o_mash_out,
    output logic              o_valid,
    output logic              o_sat
);

    localparam int HW = (ORDER_MAX > 1) ? ORDER_MAX - 1 : 1;

    logic [INT_W-1:0]                int_act;
    logic [ACC_W-1:0]                frac_act;
    logic [1:0]                      order_act;
    logic [1:0]                      order_cap;
    logic [ORDER_MAX-1:0][ACC_W-1:0] acc;
    logic [ORDER_MAX-1:0][ACC_W-1:0] acc_next;
    logic [ORDER_MAX-1:0][ACC_W:0]   sum;
    logic [ORDER_MAX-1:0]            carry;
    logic [ACC_W:0]                  stage_in;
    logic signed [4:0]               hist    [HW];
    logic signed [4:0]               hist_in [HW];
    logic signed [4:0]               lvl;
    logic signed [4:0]               e_now;
    logic signed [4:0]               e_reg;
    logic                            v1;
    logic [LFSR_W-1:0]               lfsr;
    logic                            lfsr_fb;
    logic                            dither_bit;
    logic signed [INT_W+1:0]         out_sum;
    logic [INT_W-1:0]                clamp_val;
    logic                            clamp_hit;

    assign order_cap  = (int'(i_order) > ORDER_MAX - 1) ? 2'(ORDER_MAX - 1) : i_order;
    assign dither_bit = i_dither_en & lfsr[0];
    // x^12 + x^11 + x^10 + x^4 + 1, Fibonacci form, new bit enters at bit 0
    assign lfsr_fb    = lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2] ^ lfsr[LFSR_W-3] ^ lfsr[3];

    // Accumulator cascade. Stages above the active order are held at zero
    // and contribute no carry.
    always_comb begin
        sum      = '0;
        carry    = '0;
        acc_next = '0;
        stage_in = {1'b0, frac_act} + {{ACC_W{1'b0}}, dither_bit};
        for (int k = 0; k < ORDER_MAX; k++) begin
            sum[k] = {1'b0, acc[k]} + stage_in;
            if (k <= int'(order_act)) begin
                carry[k]    = sum[k][ACC_W];
                acc_next[k] = sum[k][ACC_W-1:0];
            end
            stage_in = {1'b0, sum[k][ACC_W-1:0]};
        end
    end

    // Noise cancellation in nested form: u_top = c_top, u_k = c_k + (u_{k+1}
    // - u_{k+1}[n-1]), e = u_1. This expands to the binomial-weighted carry
    // sum and only needs one delayed value per level. Every history slot is
    // zero whenever the raw carry history would be zero, so the results are
    // identical.
    always_comb begin
        for (int k = 0; k < HW; k++) begin
            hist_in[k] = hist[k];
        end
        lvl = $signed({4'b0000, carry[ORDER_MAX-1]});
        for (int k = ORDER_MAX - 2; k >= 0; k--) begin
            hist_in[k] = lvl;
            lvl        = $signed({4'b0000, carry[k]}) + lvl - hist[k];
        end
        e_now = lvl;
    end

    // The sum is kept at INT_W+2 bits signed so that both under- and
    // overflow are visible before the clamp.
    always_comb begin
        out_sum   = $signed({2'b00, int_act}) + $signed({{(INT_W-3){e_reg[4]}}, e_reg});
        clamp_val = out_sum[INT_W-1:0];
        clamp_hit = 1'b0;
        if (out_sum[INT_W+1]) begin
            clamp_val = '0;
            clamp_hit = 1'b1;
        end else if (out_sum[INT_W]) begin
            clamp_val = '1;
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            int_act    <= '0;
            frac_act   <= '0;
            order_act  <= '0;
            acc        <= '0;
            for (int k = 0; k < HW; k++) begin
                hist[k] <= '0;
            end
            e_reg      <= '0;
            v1         <= 1'b0;
            o_mash_out <= '0;
            o_valid    <= 1'b0;
            o_sat      <= 1'b0;
            lfsr       <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else begin
            o_valid <= v1;
            if (v1) begin
                o_mash_out <= clamp_val;
                o_sat      <= clamp_hit;
            end
            v1 <= i_en;
            if (i_en) begin
                acc   <= acc_next;
                for (int k = 0; k < HW; k++) begin
                    hist[k] <= hist_in[k];
                end
                e_reg <= e_now;
                lfsr  <= {lfsr[LFSR_W-2:0], lfsr_fb};
            end
            // An order change restarts the cascade from zero. It takes
            // priority over the advance made in the same cycle.
            if (i_load) begin
                int_act   <= i_int;
                frac_act  <= i_frac;
                order_act <= order_cap;
                if (order_cap != order_act) begin
                    acc <= '0;
                    for (int k = 0; k < HW; k++) begin
                        hist[k] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mash_ddsm_param.sv
// Testbench for mash_ddsm_param: a fixed-vector table, hand-written corner
// sequences, and randomized stimulus checked against an arithmetic
// reference model.
module tb_mash_ddsm_param;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic        i_load;
    logic [7:0]  i_int;
    logic [23:0] i_frac;
    logic [1:0]  i_order;
    logic        i_dither_en;
    logic [11:0] i_seed;
    logic [7:0]  o_mash_out;
    logic        o_valid;
    logic        o_sat;

    int checks = 0;
    int errors = 0;

    mash_ddsm_param #(.ACC_W(24), .ORDER_MAX(4), .INT_W(8), .LFSR_W(12)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_load(i_load),
        .i_int(i_int), .i_frac(i_frac), .i_order(i_order),
        .i_dither_en(i_dither_en), .i_seed(i_seed),
        .o_mash_out(o_mash_out), .o_valid(o_valid), .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    // Reference model. m_ch[k][j] is the stage-k carry from j+1 cycles ago.
    longint m_acc [4];
    int     m_ch  [4][4];
    int     m_lfsr, m_order, m_int, m_frac, m_ereg, m_v1, m_out, m_valid, m_sat;

    function automatic int binom(input int n, input int r);
        int v = 1;
        for (int i = 0; i < r; i++) v = v * (n - i) / (i + 1);
        return v;
    endfunction

    task automatic m_clear_cascade();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            for (int j = 0; j < 4; j++) m_ch[k][j] = 0;
        end
    endtask

    task automatic m_step();
        int     c [4];
        longint inval, s;
        int     e, t, fb, no;
        if (i_rst) begin
            m_clear_cascade();
            m_order = 0; m_int = 0; m_frac = 0; m_ereg = 0;
            m_v1 = 0; m_out = 0; m_valid = 0; m_sat = 0;
            m_lfsr = (i_seed == 0) ? 1 : int'(i_seed);
            return;
        end
        if (m_v1 != 0) begin
            t     = m_int + m_ereg;
            m_sat = (t < 0 || t > 255) ? 1 : 0;
            m_out = (t < 0) ? 0 : ((t > 255) ? 255 : t);
        end
        m_valid = m_v1;
        if (i_en) begin
            inval = longint'(m_frac) + ((i_dither_en && (m_lfsr % 2 == 1)) ? 1 : 0);
            for (int k = 0; k < 4; k++) begin
                if (k <= m_order) begin
                    s        = m_acc[k] + inval;
                    c[k]     = int'(s / (longint'(1) << 24));
                    m_acc[k] = s % (longint'(1) << 24);
                    inval    = m_acc[k];
                end else begin
                    c[k]     = 0;
                    m_acc[k] = 0;
                end
            end
            e = 0;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j <= k; j++) begin
                    e += ((j % 2 == 1) ? -1 : 1) * binom(k, j) * ((j == 0) ? c[k] : m_ch[k][j-1]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                for (int j = 3; j > 0; j--) m_ch[k][j] = m_ch[k][j-1];
                m_ch[k][0] = c[k];
            end
            m_ereg = e;
            fb     = ((m_lfsr >> 11) ^ (m_lfsr >> 10) ^ (m_lfsr >> 9) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 'hFFF;
            m_v1   = 1;
        end else begin
            m_v1 = 0;
        end
        if (i_load) begin
            m_int  = int'(i_int);
            m_frac = int'(i_frac);
            no     = (int'(i_order) > 3) ? 3 : int'(i_order);
            if (no != m_order) m_clear_cascade();
            m_order = no;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        m_step();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".out"},   o_mash_out, m_out);
        chk({tag, ".valid"}, o_valid,    m_valid);
        chk({tag, ".sat"},   o_sat,      m_sat);
    endtask

    task automatic set_in(input logic rst, input logic en, input logic load,
                          input logic [7:0] iv, input logic [23:0] fv,
                          input logic [1:0] ov, input logic dv);
        i_rst = rst; i_en = en; i_load = load;
        i_int = iv; i_frac = fv; i_order = ov; i_dither_en = dv;
    endtask

    typedef struct {
        logic       rst, en, load;
        logic [7:0] int_v;
        logic [1:0] ord;
        logic [11:0] seed;
        int         exp_out, exp_valid, exp_sat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic load,
                                input logic [7:0] iv, input logic [1:0] ov,
                                input logic [11:0] sd, input int eo, input int ev, input int es);
        vec_t v;
        v.rst = rst; v.en = en; v.load = load; v.int_v = iv; v.ord = ov; v.seed = sd;
        v.exp_out = eo; v.exp_valid = ev; v.exp_sat = es;
        return v;
    endfunction

    task automatic run_sum(input logic [1:0] ord, input string nm);
        longint total;
        int     cnt, cyc;
        i_seed = 12'h3C1;
        set_in(1, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 1, 8'd100, 24'h800000, ord, 0); tick();
        set_in(0, 1, 0, 8'd100, 24'h800000, ord, 0);
        total = 0; cnt = 0; cyc = 0;
        while (cnt < 1024 && cyc < 1200) begin
            tick();
            cyc++;
            if (o_valid) begin
                total += o_mash_out;
                cnt++;
            end
        end
        chk({nm, ".count"}, cnt, 1024);
        chk({nm, ".sum"}, total, 102912);
    endtask

    initial begin
        i_seed = 12'h5A5;
        set_in(1, 0, 0, 0, 24'h400000, 0, 0);

        // Order 1, frac 1/4: 10,10,10,11 pattern, idle hold, then saturation at 255
        tbl.push_back(mk(1, 0, 0, 8'd0,   0, 12'h5A5, 0,   0, 0));
        tbl.push_back(mk(0, 0, 1, 8'd10,  0, 12'h5A5, 0,   0, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 0,   0, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 11,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 11,  1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 0, 0, 8'd10,  0, 12'h5A5, 10,  0, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  0, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd10,  0, 12'h5A5, 11,  1, 0));
        tbl.push_back(mk(0, 1, 1, 8'd255, 0, 12'h5A5, 10,  1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd255, 0, 12'h5A5, 255, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd255, 0, 12'h5A5, 255, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'd255, 0, 12'h5A5, 255, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'd255, 0, 12'h5A5, 255, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'd0,   0, 12'h000, 0,   0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].int_v, 24'h400000, tbl[i].ord, 0);
            i_seed = tbl[i].seed;
            tick();
            chk($sformatf("tbl%0d.out", i),   o_mash_out, tbl[i].exp_out);
            chk($sformatf("tbl%0d.valid", i), o_valid,    tbl[i].exp_valid);
            chk($sformatf("tbl%0d.sat", i),   o_sat,      tbl[i].exp_sat);
            if (tbl[i].rst)
                chk($sformatf("tbl%0d.lfsr", i), dut.lfsr, (tbl[i].seed == 0) ? 1 : tbl[i].seed);
        end

        // Order 3, frac 0: constant 37, valid rises on the second enabled edge
        i_seed = 12'h123;
        set_in(1, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 1, 8'd37, 24'd0, 2'd2, 0); tick();
        set_in(0, 1, 0, 8'd37, 24'd0, 2'd2, 0);
        tick();
        chk("ord3.valid_edge1", o_valid, 0);
        tick();
        chk("ord3.valid_edge2", o_valid, 1);
        chk("ord3.out_first", o_mash_out, 37);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("ord3.out", o_mash_out, 37);
            chk("ord3.sat", o_sat, 0);
        end

        // Mean over 1024 outputs for half-fraction, order 2 and order 4
        run_sum(2'd1, "sum_ord2");
        run_sum(2'd3, "sum_ord4");

        // Saturation at both rails, order 4, tiny fraction
        i_seed = 12'h7E3;
        set_in(1, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 1, 8'd0, 24'h000123, 2'd3, 0); tick();
        set_in(0, 1, 0, 8'd0, 24'h000123, 2'd3, 0);
        for (int i = 0; i < 4096; i++) begin tick(); cmp_model("sat_lo"); end
        set_in(1, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 1, 8'd255, 24'h000123, 2'd3, 0); tick();
        set_in(0, 1, 0, 8'd255, 24'h000123, 2'd3, 0);
        for (int i = 0; i < 4096; i++) begin tick(); cmp_model("sat_hi"); end

        // Mid-run order change clears the cascade; same-order reload does not
        set_in(1, 0, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 1, 8'd50, 24'h9A3517, 2'd1, 1); tick();
        set_in(0, 1, 0, 8'd50, 24'h9A3517, 2'd1, 1);
        for (int i = 0; i < 37; i++) begin tick(); cmp_model("reord.pre"); end
        set_in(0, 1, 1, 8'd50, 24'h9A3517, 2'd2, 1); tick();
        for (int k = 0; k < 4; k++) chk($sformatf("reord.acc%0d_clr", k), dut.acc[k], 0);
        cmp_model("reord.edge");
        set_in(0, 1, 0, 8'd50, 24'h9A3517, 2'd2, 1);
        for (int i = 0; i < 40; i++) begin tick(); cmp_model("reord.post"); end
        set_in(0, 1, 1, 8'd51, 24'h31CC05, 2'd2, 1); tick();
        for (int k = 0; k < 4; k++) chk($sformatf("reload.acc%0d", k), dut.acc[k], m_acc[k]);
        set_in(0, 1, 0, 8'd51, 24'h31CC05, 2'd2, 1);
        for (int i = 0; i < 40; i++) begin tick(); cmp_model("reload"); end

        // i_en toggling, then reset mid-stream with explicit and zero seeds
        for (int i = 0; i < 200; i++) begin
            i_en = ($urandom_range(0, 2) != 0);
            tick();
            cmp_model("toggle");
        end
        i_seed = 12'hABC;
        set_in(1, 1, 1, 8'd99, 24'h123456, 2'd3, 1); tick();
        chk("rst.lfsr_seed", dut.lfsr, 12'hABC);
        cmp_model("rst.seed");
        i_seed = 12'h000;
        tick();
        chk("rst.lfsr_zero_seed", dut.lfsr, 1);
        cmp_model("rst.zero");

        // Randomized stimulus against the reference model
        set_in(0, 0, 1, 8'd128, 24'h555555, 2'd3, 1); tick();
        for (int i = 0; i < 3000; i++) begin
            i_rst  = ($urandom_range(0, 199) == 0);
            i_seed = 12'($urandom());
            i_en   = ($urandom_range(0, 3) != 0);
            i_load = ($urandom_range(0, 19) == 0);
            if (i_load) begin
                i_int       = 8'($urandom());
                i_frac      = 24'($urandom());
                i_order     = 2'($urandom());
                i_dither_en = 1'($urandom());
            end
            tick();
            cmp_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
